// File: rtl/display_pkg.sv
// Shared scan-controller types: FSM state encoding and one-hot digit select.
package display_pkg;

  localparam int MAX_DIG = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_LOAD  = 2'd2,
    S_HOLD  = 2'd3
  } scan_state_e;

  function automatic logic [MAX_DIG-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Per-digit hold counter: counts 0..PRESCALE-1 while inc is high, tc on the last count.
module scan_prescaler #(
  parameter int PRESCALE = 3000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(PRESCALE + 1);

  logic [CW-1:0] count;

  assign tc = (count == CW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        count <= '0;
    else if (clr)     count <= '0;
    else if (inc)     count <= tc ? '0 : count + CW'(1);
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan: BLANK/LOAD/HOLD per digit against an external
// registered-output segment ROM, with a per-frame snapshot of value/blank.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int AW       = 4,
  parameter int DW       = 7,
  parameter int PRESCALE = 3000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [AW*NDIG-1:0] value,
  input  logic [NDIG-1:0]    blank,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data,
  output logic [DW-1:0]      seg,
  output logic [NDIG-1:0]    dig,
  output logic               frame_tick
);

  localparam int IW = $clog2(NDIG);

  scan_state_e state, state_nx;

  logic [IW-1:0]      idx, idx_nx;
  logic [AW*NDIG-1:0] value_r;
  logic [NDIG-1:0]    blank_r;
  logic [MAX_DIG-1:0] dig_oh;
  logic               last_dig;
  logic               hold_tc;
  logic               snap, load_seg, advance;

  assign last_dig = (idx == IW'(NDIG - 1));
  assign idx_nx   = last_dig ? '0 : idx + IW'(1);
  assign dig_oh   = onehot(3'(idx));

  scan_prescaler #(.PRESCALE(PRESCALE)) u_hold (
    .clk  (clk),
    .rstn (rstn),
    .clr  (load_seg),
    .inc  (state == S_HOLD),
    .tc   (hold_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // en low overrides every transition, including the end-of-frame tick.
  always_comb begin
    state_nx = state;
    snap     = 1'b0;
    load_seg = 1'b0;
    advance  = 1'b0;
    if (!en) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          snap     = 1'b1;
          state_nx = S_BLANK;
        end
        S_BLANK: state_nx = S_LOAD;
        S_LOAD: begin
          load_seg = 1'b1;
          state_nx = S_HOLD;
        end
        S_HOLD: begin
          if (hold_tc) begin
            advance  = 1'b1;
            snap     = last_dig;
            state_nx = S_BLANK;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx        <= '0;
      value_r    <= '0;
      blank_r    <= '0;
      rom_addr   <= '0;
      seg        <= '0;
      dig        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!en) begin
        dig <= '0;
        seg <= '0;
      end else begin
        if (snap) begin
          value_r <= value;
          blank_r <= blank;
        end
        if (state == S_IDLE) begin
          idx      <= '0;
          rom_addr <= value[AW-1:0];
          dig      <= '0;
        end
        if (load_seg) begin
          seg <= blank_r[idx] ? '0 : rom_data;
          dig <= dig_oh[NDIG-1:0];
        end
        // Wrapping fetches digit 0 from the fresh input, not the stale snapshot.
        if (advance) begin
          dig        <= '0;
          idx        <= idx_nx;
          rom_addr   <= last_dig ? value[AW-1:0] : value_r[AW*idx_nx +: AW];
          frame_tick <= last_dig;
        end
      end
    end
  end

endmodule
